// File: rtl/mul_pipe.sv
// Parametrised pipelined integer multiplier with bubble-collapsing backpressure,
// flush and decode hazard query. Define MUL_PIPE_HIGH_EN to add the in_high upper-half select.
module mul_pipe #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned STAGES           = 5,
    parameter int unsigned REG_ADDRESS_SIZE = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_operand1,
    input  logic [DATA_WIDTH-1:0]         in_operand2,
    input  logic [REG_ADDRESS_SIZE-1:0]   in_dest,
`ifdef MUL_PIPE_HIGH_EN
    input  logic                          in_high,
`endif
    output logic                          in_stall,
    input  logic                          flush,
    input  logic                          out_stall_in,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_result,
    output logic [REG_ADDRESS_SIZE-1:0]   out_dest,
    input  logic [REG_ADDRESS_SIZE-1:0]   query_reg,
    output logic                          hazard,
    output logic [$clog2(STAGES+1)-1:0]   hazard_stage
);

    localparam int unsigned HSW = $clog2(STAGES + 1);

    logic [STAGES-1:0]           valid_q;
    logic [STAGES-1:0]           adv_c;
    logic [STAGES-1:0]           load_c;
    logic [REG_ADDRESS_SIZE-1:0] dest_q [STAGES];
    logic [DATA_WIDTH-1:0]       op1_q;
    logic [DATA_WIDTH-1:0]       op2_q;
    logic [DATA_WIDTH-1:0]       res_q  [1:STAGES-1];
    logic [DATA_WIDTH-1:0]       prod_c;
    logic                        accept_c;

    // Stage 1 holds operands; the product is formed on the way into stage 2.
`ifdef MUL_PIPE_HIGH_EN
    logic                        high_q;
    logic [2*DATA_WIDTH-1:0]     full_c;
    assign full_c = (2*DATA_WIDTH)'(op1_q) * (2*DATA_WIDTH)'(op2_q);
    assign prod_c = high_q ? full_c[2*DATA_WIDTH-1:DATA_WIDTH] : full_c[DATA_WIDTH-1:0];
`else
    assign prod_c = op1_q * op2_q;
`endif

    // Advance chain from the output back to stage 1; an empty stage can always load.
    always_comb begin
        adv_c = '0;
        adv_c[STAGES-1] = !out_stall_in || !valid_q[STAGES-1];
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            adv_c[i] = !valid_q[i+1] || adv_c[i+1];
        end
        load_c = ~valid_q | adv_c;
    end

    assign in_stall = valid_q[0] && !adv_c[0];
    assign accept_c = in_valid && !in_stall && !flush;

    // Youngest matching stage wins because the scan ends at stage 1.
    always_comb begin
        hazard       = 1'b0;
        hazard_stage = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            if (valid_q[i] && dest_q[i] == query_reg) begin
                hazard       = 1'b1;
                hazard_stage = HSW'(i + 1);
            end
        end
        if (query_reg == '0) begin
            hazard       = 1'b0;
            hazard_stage = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
`ifdef MUL_PIPE_HIGH_EN
            high_q  <= 1'b0;
`endif
            for (int i = 0; i < int'(STAGES); i++) begin
                dest_q[i] <= '0;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                res_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (load_c[0]) valid_q[0] <= in_valid;
                for (int i = 1; i < int'(STAGES); i++) begin
                    if (load_c[i]) valid_q[i] <= valid_q[i-1];
                end
            end
            if (accept_c) begin
                op1_q     <= in_operand1;
                op2_q     <= in_operand2;
                dest_q[0] <= in_dest;
`ifdef MUL_PIPE_HIGH_EN
                high_q    <= in_high;
`endif
            end
            if (load_c[1] && valid_q[0]) begin
                res_q[1]  <= prod_c;
                dest_q[1] <= dest_q[0];
            end
            for (int i = 2; i < int'(STAGES); i++) begin
                if (load_c[i] && valid_q[i-1]) begin
                    res_q[i]  <= res_q[i-1];
                    dest_q[i] <= dest_q[i-1];
                end
            end
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_result = res_q[STAGES-1];
    assign out_dest   = dest_q[STAGES-1];

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: vector table, directed pipeline corner cases, and a
// randomized run against an in-flight queue model.
module tb_mul_pipe;

    localparam int DW  = 32;
    localparam int ST  = 5;
    localparam int RW  = 5;
    localparam int HSW = $clog2(ST + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [DW-1:0]  in_operand1;
    logic [DW-1:0]  in_operand2;
    logic [RW-1:0]  in_dest;
    logic           in_high;
    logic           in_stall;
    logic           flush;
    logic           out_stall_in;
    logic           out_valid;
    logic [DW-1:0]  out_result;
    logic [RW-1:0]  out_dest;
    logic [RW-1:0]  query_reg;
    logic           hazard;
    logic [HSW-1:0] hazard_stage;

    always #5 clk = ~clk;

    mul_pipe #(.DATA_WIDTH(DW), .STAGES(ST), .REG_ADDRESS_SIZE(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_operand1  (in_operand1),
        .in_operand2  (in_operand2),
        .in_dest      (in_dest),
`ifdef MUL_PIPE_HIGH_EN
        .in_high      (in_high),
`endif
        .in_stall     (in_stall),
        .flush        (flush),
        .out_stall_in (out_stall_in),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_dest     (out_dest),
        .query_reg    (query_reg),
        .hazard       (hazard),
        .hazard_stage (hazard_stage)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] res;
        logic [RW-1:0] dest;
    } exp_t;

    exp_t q[$];

    function automatic logic [DW-1:0] ref_mul(logic [DW-1:0] a, logic [DW-1:0] b, logic h);
        logic [2*DW-1:0] p;
        p = (2*DW)'(a) * (2*DW)'(b);
`ifdef MUL_PIPE_HIGH_EN
        if (h) return p[2*DW-1:DW];
`endif
        return h ? p[DW-1:0] : p[DW-1:0];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic v, logic [DW-1:0] a, logic [DW-1:0] b, logic [RW-1:0] d);
        in_valid    = v;
        in_operand1 = a;
        in_operand2 = b;
        in_dest     = d;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        flush        = 1'b0;
        out_stall_in = 1'b0;
        query_reg    = '0;
        in_high      = 1'b0;
        set_in(1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   j;
        int   seen;
        logic acc;
        logic cons;
        logic exp_stall;
        logic exp_haz;

        // Reset values
        reset = 1'b0;
        flush = 1'b0;
        out_stall_in = 1'b0;
        in_high = 1'b0;
        set_in(1'b0, '0, '0, '0);
        query_reg = 5'd3;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_dest", out_dest, 0);
        check("rst_in_stall", in_stall, 0);
        check("rst_hazard", hazard, 0);
        check("rst_hazard_stage", hazard_stage, 0);

        // Vector table, issued back-to-back with no backpressure
        tbl[0] = '{32'd7,         32'd6,         5'd3,  32'd42};
        tbl[1] = '{32'hFFFFFFFF,  32'd2,         5'd1,  32'hFFFFFFFE};
        tbl[2] = '{32'd0,         32'd123,       5'd2,  32'd0};
        tbl[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  5'd31, 32'd1};
        tbl[4] = '{32'd10000,     32'd10000,     5'd8,  32'h05F5E100};
        tbl[5] = '{32'h80000000,  32'd2,         5'd5,  32'd0};
        tbl[6] = '{32'h12345678,  32'h10,        5'd6,  32'h23456780};
        tbl[7] = '{32'h00010000,  32'h00010001,  5'd7,  32'h00010000};
        do_reset();
        for (int c = 0; c < 8 + ST; c++) begin
            if (c < 8) set_in(1'b1, tbl[c].a, tbl[c].b, tbl[c].d);
            else       set_in(1'b0, '0, '0, '0);
            #1;
            check("tbl_in_stall", in_stall, 0);
            tick();
            j = c - ST + 1;
            if (j >= 0 && j < 8) begin
                check("tbl_out_valid", out_valid, 1);
                check("tbl_out_result", out_result, tbl[j].exp);
                check("tbl_out_dest", out_dest, tbl[j].d);
            end else begin
                check("tbl_out_idle", out_valid, 0);
            end
        end

`ifdef MUL_PIPE_HIGH_EN
        do_reset();
        in_high = 1'b1;
        set_in(1'b1, 32'hFFFFFFFF, 32'd2, 5'd1);
        tick();
        in_high = 1'b0;
        set_in(1'b0, '0, '0, '0);
        repeat (ST - 1) tick();
        check("high_valid", out_valid, 1);
        check("high_result", out_result, 32'h00000001);
`endif

        // Backpressure fills every stage before in_stall rises
        do_reset();
        out_stall_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, DW'(i + 1), 32'd3, RW'(i + 1));
            #1;
            check("bp_in_stall", in_stall, (i >= ST) ? 1 : 0);
            tick();
            if (i >= ST - 1) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_result", out_result, 32'd3);
            end
        end
        set_in(1'b0, '0, '0, '0);
        query_reg = 5'd3;
        #1;
        check("bp_haz3_stage", hazard_stage, 3);
        query_reg = 5'd5;
        #1;
        check("bp_haz5_stage", hazard_stage, 1);
        query_reg = 5'd9;
        #1;
        check("bp_haz9", hazard, 0);
        out_stall_in = 1'b0;
        for (int k = 0; k < ST; k++) begin
            #1;
            check("bp_drain_valid", out_valid, 1);
            check("bp_drain_result", out_result, ref_mul(DW'(k + 1), 32'd3, 1'b0));
            check("bp_drain_dest", out_dest, k + 1);
            tick();
        end
        check("bp_drain_end", out_valid, 0);

        // Flush with a same-cycle input
        do_reset();
        set_in(1'b1, 32'd2, 32'd5, 5'd4); tick();
        set_in(1'b1, 32'd3, 32'd5, 5'd4); tick();
        set_in(1'b1, 32'd4, 32'd5, 5'd9); tick();
        query_reg = 5'd4;
        set_in(1'b1, 32'd11, 32'd11, 5'd7);
        #1;
        check("fl_pre_haz", hazard, 1);
        check("fl_pre_stage", hazard_stage, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, '0, '0, '0);
        check("fl_out_valid", out_valid, 0);
        check("fl_haz4", hazard, 0);
        query_reg = 5'd9;
        #1;
        check("fl_haz9", hazard, 0);
        query_reg = 5'd7;
        #1;
        check("fl_haz7", hazard, 0);
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        check("fl_no_emerge", seen, 0);

        // Hazard stage reporting and query of register 0
        do_reset();
        set_in(1'b1, 32'd1, 32'd1, 5'd4); tick();
        set_in(1'b1, 32'd1, 32'd1, 5'd6); tick();
        set_in(1'b1, 32'd1, 32'd1, 5'd4); tick();
        set_in(1'b1, 32'd1, 32'd1, 5'd0); tick();
        set_in(1'b0, '0, '0, '0);
        query_reg = 5'd4;
        #1;
        check("hz_q4", hazard, 1);
        check("hz_q4_stage", hazard_stage, 2);
        query_reg = 5'd6;
        #1;
        check("hz_q6_stage", hazard_stage, 3);
        query_reg = 5'd0;
        #1;
        check("hz_q0", hazard, 0);
        check("hz_q0_stage", hazard_stage, 0);

        // Asynchronous reset mid-operation
        do_reset();
        out_stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, DW'(5 + i), 32'd9, RW'(i + 1));
            tick();
        end
        set_in(1'b0, '0, '0, '0);
        repeat (3) tick();
        check("ar_pre_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_result", out_result, 0);
        check("ar_out_dest", out_dest, 0);
        #3 reset = 1'b1;
        out_stall_in = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        check("ar_no_stale", seen, 0);

        // Randomized run against the in-flight queue model
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_operand1  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            in_operand2  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : $urandom;
            in_dest      = RW'($urandom_range(0, 7));
`ifdef MUL_PIPE_HIGH_EN
            in_high      = $urandom_range(0, 1) != 0;
`endif
            flush        = ($urandom_range(0, 63) == 0);
            out_stall_in = ($urandom_range(0, 2) == 0);
            query_reg    = RW'($urandom_range(0, 7));
            #1;
            exp_stall = (q.size() == ST) && out_stall_in;
            check("rnd_in_stall", in_stall, exp_stall);
            exp_haz = 1'b0;
            foreach (q[k]) if (q[k].dest == query_reg) exp_haz = 1'b1;
            if (query_reg == '0) exp_haz = 1'b0;
            check("rnd_hazard", hazard, exp_haz);
            if (out_valid) check("rnd_pending", q.size() != 0, 1);
            acc  = in_valid && !exp_stall && !flush;
            cons = out_valid && !out_stall_in;
            if (cons && q.size() != 0) begin
                check("rnd_result", out_result, q[0].res);
                check("rnd_dest", out_dest, q[0].dest);
                void'(q.pop_front());
            end
            if (acc) q.push_back('{ref_mul(in_operand1, in_operand2, in_high), in_dest});
            tick();
            if (flush) q.delete();
        end

        set_in(1'b0, '0, '0, '0);
        flush = 1'b0;
        out_stall_in = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (out_valid && q.size() != 0) begin
                check("drain_result", out_result, q[0].res);
                check("drain_dest", out_dest, q[0].dest);
                void'(q.pop_front());
            end
            tick();
        end
        check("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised, fully pipelined integer multiply unit for the execute side of the datapath. It is the generalised successor of the fixed five-stage multiplier chain, with configurable data width and stage count. It adds per-stage valid/destination tracking, bubble-collapsing backpressure, a pipeline flush and a combinational hazard query for decode-stage bypass/stall logic. It sits between decode (DM) and write-back, in parallel with the ALU path.

## Interface

Parameters:
- `DATA_WIDTH`, 32: operand and result width.
- `STAGES`, 5: pipeline depth. Legal range is 2..16.
- `REG_ADDRESS_SIZE`, 5: destination register index width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: an operation is presented.
- `in_operand1`, input, DATA_WIDTH: multiplicand.
- `in_operand2`, input, DATA_WIDTH: multiplier.
- `in_dest`, input, REG_ADDRESS_SIZE: destination register. 0 means no write-back.
- `in_stall`, output, 1: unit cannot accept this cycle. Decode must hold.
- `flush`, input, 1: discard every in-flight operation (branch taken).
- `out_stall_in`, input, 1: write-back cannot accept the result.
- `out_valid`, output, 1: the final stage holds a result.
- `out_result`, output, DATA_WIDTH: product.
- `out_dest`, output, REG_ADDRESS_SIZE: destination of `out_result`.
- `query_reg`, input, REG_ADDRESS_SIZE: register being read by decode.
- `hazard`, output, 1: `query_reg` is a pending destination.
- `hazard_stage`, output, $clog2(STAGES+1): youngest matching stage (1..STAGES); 0 if none.

## Operation

- The pipeline has stages 1..STAGES. Each stage holds a valid bit, a destination, and intermediate data.
- Partitioning of the multiply across stages is free. Only the final-stage value is architecturally visible.
- Result is the low DATA_WIDTH bits of in_operand1 × in_operand2. This is sign-agnostic, and wrap-around is silent.
- Acceptance: an operation is accepted when `in_valid && !in_stall && !flush`. It enters stage 1 at that edge.
- Advance rule (bubble-collapsing):
  - Stage STAGES advances when `!out_stall_in` or when it is empty.
  - Stage i < STAGES advances when stage i+1 is empty or stage i+1 advances.
  - A stage that does not advance holds its contents.
  - A stage that advances without new data from below becomes empty.
- `in_stall` = stage 1 valid and stage 1 not advancing. It is combinational. It never depends on `in_valid`.
- Flush: at an edge with `flush`=1, all valid bits clear. Any same-cycle input is dropped. Flush has priority over both stall and accept.
- Hazard:
  - `hazard` = OR over stages of (valid && dest == query_reg), forced to 0 when query_reg == 0.
  - `hazard_stage` reports the lowest-numbered (youngest) match.
  - Both are purely combinational from current state.
- Write-back consumes a result on any cycle with `out_valid && !out_stall_in`.

## Timing

- Reset values: all valid bits 0, `out_valid`=0, `out_result`=0, `out_dest`=0, `in_stall`=0, `hazard`=0, `hazard_stage`=0.
- Reset mid-operation discards everything immediately. The first accept is possible on the first edge after deassertion.
- Latency: accepted at edge k, the result is visible with `out_valid`=1 in the cycle after edge k+STAGES-1 (STAGES edges inclusive). This assumes no backpressure.
- Throughput: one operation per cycle.
- While `out_stall_in`=1 and `out_valid`=1, `out_result` and `out_dest` are stable.
- Under backpressure, empty stages fill. `in_stall` rises only once every stage 1..STAGES is occupied.
- Simultaneous `flush` and `out_stall_in`: flush wins. `out_valid` is 0 next cycle.
- A flush does not disturb a result already consumed at the same edge.

## Configuration

- `MUL_PIPE_HIGH_EN` defined:
  - Adds input `in_high` (1 bit), captured with the operands and carried per stage.
  - When `in_high`=1, `out_result` is the upper DATA_WIDTH bits of the unsigned 2·DATA_WIDTH-bit product.
- `MUL_PIPE_HIGH_EN` undefined:
  - No `in_high` port.
  - Only the low half is computed, and no 2·DATA_WIDTH-bit datapath is built.

## Test plan

- Defaults, 7×6 with dest 3 accepted at edge 0 → out_valid=1, out_result=42, out_dest=3 after 5 edges. No in_stall.
- 0xFFFFFFFF×2 → out_result=0xFFFFFFFE. With `MUL_PIPE_HIGH_EN` and in_high=1 → 0x00000001.
- Issue 1 op, hold out_stall_in=1, keep issuing → in_stall asserts only after 5 ops are in flight. Release → 5 results in order on 5 consecutive cycles.
- 3 ops in flight with dest 4, 4, 9; flush asserted alongside a new input → next cycle all valid=0, hazard=0. The new op never emerges.
- Ops with dest 4 in stages 2 and 4, query_reg=4 → hazard=1, hazard_stage=2. With query_reg=0 and dest 0 in flight → hazard=0.
- Reset pulled low with 3 ops in flight and out_stall_in=1 → out_valid=0 asynchronously. No stale result after release.
